mem_stage: RTL and testbench

//  MEM pipeline stage between EX and WB. Holds one instruction.
//  For loads issued by EX, waits for the data-SRAM response (data_ok) and extracts/extends the load data.

---
 rtl/mem_stage.sv | 95 +++++++++
 tb/tb_mem_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage that waits for data-SRAM load responses, extends load data and drops orphaned responses
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = 132,
   parameter int MS_TO_WS_BUS_WD = 126,
   parameter int DISCARD_CNT_W   = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic [9:0]                 stall_ms_bus,
   output logic [33:0]                forward_ms_bus
);
   logic                       ms_valid_q, ms_valid_d;
   logic                       data_got_q, data_got_d;
   logic [31:0]                data_buf_q, data_buf_d;
   logic [DISCARD_CNT_W-1:0]   discard_cnt_q, discard_cnt_d;
   logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
   logic [2:0]  mem_op;
   logic        mem_req;
   logic [1:0]  addr_lo;
   logic [3:0]  gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic        cnt_zero, resp_take, ms_ready_go, in_wait, leaving, accept, inc, dec;
   logic [31:0] rd, ms_final_result;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic        load_pending;
   assign mem_op     = bus_q[131:129];
   assign mem_req    = bus_q[128];
   assign addr_lo    = bus_q[127:126];
   assign gr_we      = bus_q[72:69];
   assign dest       = bus_q[68:64];
   assign alu_result = bus_q[63:32];
   // Handshake: a response only counts for this entry once all orphaned responses are drained
   always_comb begin
      cnt_zero    = discard_cnt_q == '0;
      resp_take   = data_sram_data_ok && cnt_zero;
      ms_ready_go = !mem_req || data_got_q || resp_take;
      ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
      in_wait     = ms_valid_q && mem_req && !data_got_q;
      leaving     = ms_valid_q && ms_ready_go && ws_allowin;
      accept      = es_to_ms_valid && ms_allowin;
      inc         = flush && in_wait && !resp_take;
      dec         = data_sram_data_ok && !cnt_zero;
   end
   // Load data extraction from the buffered or the live response
   always_comb begin
      rd      = data_got_q ? data_buf_q : data_sram_rdata;
      rd_byte = rd[{addr_lo, 3'b000} +: 8];
      rd_half = addr_lo[1] ? rd[31:16] : rd[15:0];
      ms_final_result = mem_op == 3'd1 ? rd :
                        mem_op == 3'd2 ? {{24{rd_byte[7]}}, rd_byte} :
                        mem_op == 3'd3 ? {24'b0, rd_byte} :
                        mem_op == 3'd4 ? {{16{rd_half[15]}}, rd_half} :
                        mem_op == 3'd5 ? {16'b0, rd_half} : alu_result;
      load_pending    = ms_valid_q && mem_op != 3'd0 && !ms_ready_go;
   end
   // Next state: accept/flush, response capture while WB is blocked, orphan counting
   always_comb begin
      bus_d         = accept ? es_to_ms_bus : bus_q;
      ms_valid_d    = flush ? 1'b0 : (ms_allowin ? es_to_ms_valid : ms_valid_q);
      data_got_d    = accept ? 1'b0 : ((resp_take && in_wait && !leaving) ? 1'b1 : data_got_q);
      data_buf_d    = (resp_take && in_wait && !leaving) ? data_sram_rdata : data_buf_q;
      discard_cnt_d = discard_cnt_q + {{(DISCARD_CNT_W-1){1'b0}}, inc} - {{(DISCARD_CNT_W-1){1'b0}}, dec};
   end
   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_valid_q    <= 1'b0;
         data_got_q    <= 1'b0;
         data_buf_q    <= '0;
         discard_cnt_q <= '0;
         bus_q         <= '0;
      end else begin
         ms_valid_q    <= ms_valid_d;
         data_got_q    <= data_got_d;
         data_buf_q    <= data_buf_d;
         discard_cnt_q <= discard_cnt_d;
         bus_q         <= bus_d;
      end
   end
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
   assign ms_to_ws_bus   = {bus_q[125:64], ms_final_result, bus_q[31:0]};
   assign stall_ms_bus   = {ms_valid_q && |gr_we, gr_we & {4{ms_valid_q}}, dest};
   assign forward_ms_bus = {ms_valid_q && ms_ready_go, load_pending, ms_final_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level reference model
module tb_mem_stage;
   logic         clk = 0, reset = 1, flush = 0, ws_allowin = 1, es_to_ms_valid = 0;
   logic [131:0] es_to_ms_bus = '0;
   logic         data_ok = 0;
   logic [31:0]  rdata = '0;
   logic         ms_allowin, ms_to_ws_valid;
   logic [125:0] ms_to_ws_bus;
   logic [9:0]   stall_ms_bus;
   logic [33:0]  forward_ms_bus;
   int checks = 0, failures = 0, pcn = 32'h100;

   mem_stage dut (
      .clk(clk), .reset(reset), .flush(flush), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
      .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus), .ms_to_ws_valid(ms_to_ws_valid),
      .ms_to_ws_bus(ms_to_ws_bus), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
      .stall_ms_bus(stall_ms_bus), .forward_ms_bus(forward_ms_bus)
   );

   always #5 clk = ~clk;

   // Reference model: one held instruction, whether its response has arrived, and how many
   // responses still belong to flushed requests
   logic         m_valid = 0, m_have = 0;
   logic [31:0]  m_data = 0;
   logic [131:0] m_bus = 0;
   int           orphans = 0;

   function automatic logic [31:0] ld(input logic [2:0] op, input logic [1:0] a, input logic [31:0] d, input logic [31:0] alu);
      logic [31:0] b, h;
      b = (d >> (8 * a)) & 32'hff;
      h = a[1] ? (d >> 16) : (d & 32'hffff);
      case (op)
         3'd1: return d;
         3'd2: return b >= 128 ? (b | 32'hffffff00) : b;
         3'd3: return b;
         3'd4: return h >= 32768 ? (h | 32'hffff0000) : h;
         3'd5: return h;
         default: return alu;
      endcase
   endfunction

   function automatic logic [131:0] mk(input logic [2:0] op, input logic req, input logic [1:0] a, input logic [31:0] alu, input logic [31:0] pc);
      return {op, req, a, ~pc, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0, 4'hf, 5'd3, alu, pc};
   endfunction

   function automatic logic m_done();
      return !m_bus[128] || m_have || (data_ok && orphans == 0);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid = 0; m_have = 0; m_data = 0; m_bus = 0; orphans = 0;
      end else begin
         logic take, done, leave, acc, waiting;
         int nxt;
         take    = data_ok && orphans == 0;
         done    = m_done();
         waiting = m_valid && m_bus[128] && !m_have;
         leave   = m_valid && done && ws_allowin;
         acc     = es_to_ms_valid && (!m_valid || leave);
         nxt     = orphans + ((flush && waiting && !take) ? 1 : 0) - ((data_ok && orphans > 0) ? 1 : 0);
         if (waiting && take && !leave) begin m_have = 1; m_data = rdata; end
         if (acc) begin m_bus = es_to_ms_bus; m_have = 0; end
         m_valid = flush ? 0 : (acc ? 1 : (leave ? 0 : m_valid));
         orphans = nxt;
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      logic done, allow, wbv;
      logic [31:0] res;
      done  = m_done();
      allow = !m_valid || (done && ws_allowin);
      wbv   = m_valid && done && !flush;
      res   = ld(m_bus[131:129], m_bus[127:126], m_have ? m_data : rdata, m_bus[63:32]);
      chk("allowin", {31'b0, ms_allowin}, {31'b0, allow});
      chk("wb_valid", {31'b0, ms_to_ws_valid}, {31'b0, wbv});
      chk("stall_bus", {22'b0, stall_ms_bus}, {22'b0, m_valid && |m_bus[72:69], m_bus[72:69] & {4{m_valid}}, m_bus[68:64]});
      chk("fwd_flags", {30'b0, forward_ms_bus[33:32]}, {30'b0, m_valid && done, m_valid && m_bus[131:129] != 0 && !done});
      if (m_valid && done) begin
         chk("fwd_result", forward_ms_bus[31:0], res);
         checks++;
         if (ms_to_ws_bus !== {m_bus[125:64], res, m_bus[31:0]}) begin
            failures++;
            $display("FAIL wb_bus: got %h expected %h at %0t", ms_to_ws_bus, {m_bus[125:64], res, m_bus[31:0]}, $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic req, input logic [1:0] a, input logic [31:0] alu);
      es_to_ms_valid = 1; es_to_ms_bus = mk(op, req, a, alu, pcn); pcn += 4;
      tick();
      es_to_ms_valid = 0;
   endtask

   task automatic do_load(input string n, input logic [2:0] op, input logic [1:0] a, input logic [31:0] d, input logic [31:0] e);
      ws_allowin = 1;
      issue(op, 1, a, 32'h0);
      @(negedge clk);
      chk({n, "_stall"}, {31'b0, stall_ms_bus[9]}, 1);
      chk({n, "_pending"}, {31'b0, forward_ms_bus[32]}, 1);
      chk({n, "_wait"}, {31'b0, ms_to_ws_valid}, 0);
      tick();
      data_ok = 1; rdata = d;
      @(negedge clk);
      chk({n, "_valid"}, {31'b0, ms_to_ws_valid}, 1);
      chk({n, "_result"}, ms_to_ws_bus[63:32], e);
      tick();
      data_ok = 0; rdata = 32'h5a5a5a5a;
   endtask

   initial begin
      tick(); tick();
      @(negedge clk);
      chk("rst_valid", {31'b0, ms_to_ws_valid}, 0);
      chk("rst_stall", {22'b0, stall_ms_bus}, 0);
      chk("rst_allowin", {31'b0, ms_allowin}, 1);
      tick();
      reset = 0;
      tick();
      do_load("lw", 3'd1, 2'd0, 32'h8badf00d, 32'h8badf00d);
      do_load("lb", 3'd2, 2'd2, 32'h00800000, 32'hffffff80);
      do_load("lbu", 3'd3, 2'd2, 32'h00800000, 32'h00000080);
      do_load("lh", 3'd4, 2'd2, 32'h80010000, 32'hffff8001);
      do_load("lhu", 3'd5, 2'd2, 32'h80010000, 32'h00008001);
      // response captured while WB is blocked
      ws_allowin = 0;
      issue(3'd1, 1, 2'd0, 32'h0);
      data_ok = 1; rdata = 32'h1234;
      tick();
      data_ok = 0; rdata = 32'hffffffff;
      tick(); tick(); tick();
      @(negedge clk);
      chk("hold_valid", {31'b0, ms_to_ws_valid}, 1);
      chk("hold_result", ms_to_ws_bus[63:32], 32'h1234);
      ws_allowin = 1;
      tick();
      @(negedge clk);
      chk("hold_once", {31'b0, ms_to_ws_valid}, 0);
      // flush while waiting leaves one orphaned response
      tick();
      issue(3'd1, 1, 2'd0, 32'h0);
      flush = 1;
      tick();
      flush = 0;
      @(negedge clk);
      chk("flush_allowin", {31'b0, ms_allowin}, 1);
      issue(3'd1, 1, 2'd0, 32'h0);
      data_ok = 1; rdata = 32'hdead;
      @(negedge clk);
      chk("discard_drop", {31'b0, ms_to_ws_valid}, 0);
      tick();
      rdata = 32'hbeef;
      @(negedge clk);
      chk("discard_valid", {31'b0, ms_to_ws_valid}, 1);
      chk("discard_result", ms_to_ws_bus[63:32], 32'hbeef);
      tick();
      data_ok = 0;
      // ALU ops back to back, then a flush on a valid entry
      es_to_ms_valid = 1; es_to_ms_bus = mk(3'd0, 0, 2'd0, 32'd7, pcn); pcn += 4;
      tick();
      es_to_ms_bus = mk(3'd0, 0, 2'd0, 32'd8, pcn); pcn += 4;
      @(negedge clk);
      chk("alu7", ms_to_ws_bus[63:32], 32'd7);
      chk("alu7_valid", {31'b0, ms_to_ws_valid}, 1);
      tick();
      es_to_ms_bus = mk(3'd0, 0, 2'd0, 32'd9, pcn); pcn += 4;
      @(negedge clk);
      chk("alu8", ms_to_ws_bus[63:32], 32'd8);
      tick();
      es_to_ms_valid = 0; flush = 1;
      @(negedge clk);
      chk("flush_kill", {31'b0, ms_to_ws_valid}, 0);
      tick();
      flush = 0;
      @(negedge clk);
      chk("flush_empty", {31'b0, stall_ms_bus[9]}, 0);
      // two orphans then asynchronous reset mid-wait
      tick();
      issue(3'd1, 1, 2'd0, 32'h0);
      flush = 1; tick(); flush = 0;
      issue(3'd1, 1, 2'd0, 32'h0);
      flush = 1; tick(); flush = 0;
      issue(3'd1, 1, 2'd0, 32'h0);
      @(negedge clk);
      chk("pre_rst_stall", {31'b0, stall_ms_bus[9]}, 1);
      #2 reset = 1;
      #1;
      chk("arst_stall", {31'b0, stall_ms_bus[9]}, 0);
      chk("arst_allowin", {31'b0, ms_allowin}, 1);
      chk("arst_fwd", {30'b0, forward_ms_bus[33:32]}, 0);
      tick(); tick();
      reset = 0;
      issue(3'd1, 1, 2'd0, 32'h0);
      data_ok = 1; rdata = 32'h55;
      @(negedge clk);
      chk("post_rst_valid", {31'b0, ms_to_ws_valid}, 1);
      chk("post_rst_result", ms_to_ws_bus[63:32], 32'h55);
      tick();
      data_ok = 0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
